// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control path: FSM states,
// instruction field codes and datapath mux encodings.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_DIVWAIT = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_MEM = 2'b10;

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_MUL = 3'b001;
    localparam logic [2:0] CMD_DIV = 3'b010;
    localparam logic [2:0] CMD_MOD = 3'b011;
    localparam logic [2:0] CMD_MOV = 3'b100;
    localparam logic [2:0] CMD_EQV = 3'b101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_EQV = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;
    localparam logic [2:0] ALU_MOD = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the datapath / divider.
interface multicycle_controller_if;
    logic [1:0] Op;
    logic [4:0] Funct;
    logic [3:0] Rd;
    logic       cond_ex;
    logic       div_done;
    logic       IRWrite;
    logic       AdrSrc;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [2:0] ALUControl;
    logic [1:0] FlagW;
    logic       div_start;
    logic       illegal;
    logic       div_abort;
    logic [3:0] state;

    modport master (
        input  Op, Funct, Rd, cond_ex, div_done,
        output IRWrite, AdrSrc, PCWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB,
               ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW, div_start,
               illegal, div_abort, state
    );

    modport slave (
        output Op, Funct, Rd, cond_ex, div_done,
        input  IRWrite, AdrSrc, PCWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB,
               ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW, div_start,
               illegal, div_abort, state
    );
endinterface

// File: rtl/alu_cmd_map.sv
// Decodes the DP cmd field into the ALU operation and its write/divider attributes.
module alu_cmd_map
    import cpu_pkg::*;
(
    input  logic [2:0] cmd,
    output logic [2:0] alu_control,
    output logic       no_write,
    output logic       is_div,
    output logic       legal
);
    always_comb begin
        alu_control = ALU_ADD;
        no_write    = 1'b0;
        is_div      = 1'b0;
        legal       = 1'b1;
        case (cmd)
            CMD_ADD: alu_control = ALU_ADD;
            CMD_MUL: alu_control = ALU_MUL;
            CMD_DIV: begin alu_control = ALU_DIV; is_div = 1'b1; end
            CMD_MOD: begin alu_control = ALU_MOD; is_div = 1'b1; end
            CMD_MOV: alu_control = ALU_MOV;
            CMD_EQV: begin alu_control = ALU_EQV; no_write = 1'b1; end
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle CPU: sequences the shared ALU, register
// file and memory port, and handshakes with the iterative divider.
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int PC_REG      = 9,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    localparam int CW = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic [2:0] map_alu;
    logic       map_no_write, map_is_div, map_legal;

    logic       ir_write, adr_src, pc_write, reg_write, mem_write, alu_src_a;
    logic [1:0] alu_src_b, result_src, imm_src, reg_src, flag_w;
    logic [2:0] alu_control;
    logic       div_start_c, illegal_c, div_abort_c;

    alu_cmd_map u_map (
        .cmd         (bus.Funct[3:1]),
        .alu_control (map_alu),
        .no_write    (map_no_write),
        .is_div      (map_is_div),
        .legal       (map_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = '0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        result_src  = RES_ALUOUT;
        imm_src     = 2'b00;
        reg_src     = 2'b00;
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        div_start_c = 1'b0;
        illegal_c   = 1'b0;
        div_abort_c = 1'b0;

        // Extension/read selects stay valid after DECODE so EXECI/MEMADR/BRANCH see the right immediate.
        if (state_reg != S_FETCH) begin
            case (bus.Op)
                OP_BR:   begin reg_src = 2'b01; imm_src = 2'b10; end
                OP_MEM:  begin reg_src = 2'b10; imm_src = 2'b01; end
                default: ;
            endcase
        end

        case (state_reg)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                case (bus.Op)
                    OP_MEM:  state_next = S_MEMADR;
                    OP_DP:   state_next = bus.Funct[4] ? S_EXECI : S_EXECR;
                    OP_BR:   state_next = S_BRANCH;
                    default: begin illegal_c = 1'b1; state_next = S_FETCH; end
                endcase
            end
            S_MEMADR: begin
                alu_src_b  = SRCB_IMM;
                state_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src    = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = bus.cond_ex;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                adr_src    = 1'b1;
                mem_write  = bus.cond_ex;
                state_next = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_b   = (state_reg == S_EXECI) ? SRCB_IMM : SRCB_REG;
                alu_control = map_alu;
                if (!map_legal) begin
                    illegal_c  = 1'b1;
                    state_next = S_FETCH;
                end else if (map_is_div) begin
                    div_start_c = 1'b1;
                    state_next  = S_DIVWAIT;
                end else begin
                    state_next = S_ALUWB;
                end
            end
            S_DIVWAIT: begin
                alu_control = map_alu;
                // A completing divide beats a timeout landing in the same cycle.
                if (bus.div_done) begin
                    state_next = S_ALUWB;
                end else if (cnt_reg == CNT_LAST) begin
                    div_abort_c = 1'b1;
                    state_next  = S_FETCH;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_ALUWB: begin
                alu_control = map_alu;
                reg_write   = bus.cond_ex & ~map_no_write;
                pc_write    = reg_write & (bus.Rd == 4'(PC_REG));
                flag_w      = {2{bus.Funct[0] & bus.cond_ex}};
                state_next  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_write   = bus.cond_ex;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign bus.IRWrite    = ir_write & ~reset;
    assign bus.PCWrite    = pc_write & ~reset;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.MemWrite   = mem_write & ~reset;
    assign bus.FlagW      = flag_w & {2{~reset}};
    assign bus.div_start  = div_start_c & ~reset;
    assign bus.illegal    = illegal_c & ~reset;
    assign bus.div_abort  = div_abort_c & ~reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ImmSrc     = imm_src;
    assign bus.RegSrc     = reg_src;
    assign bus.ALUControl = alu_control;
    assign bus.state      = state_reg;
endmodule
